// File: rtl/video_syncgen_pkg.sv
// video_syncgen_pkg
//   Shared definitions for the video timing generator:
//   720p60 timing defaults, coordinate widths, pattern_sel encodings,
//   colour-bar palette and bar width.
package video_syncgen_pkg;

  localparam int unsigned H_ACTIVE_720P = 1280;
  localparam int unsigned H_FRONT_720P  = 110;
  localparam int unsigned H_SYNC_720P   = 40;
  localparam int unsigned H_BACK_720P   = 220;
  localparam int unsigned V_ACTIVE_720P = 720;
  localparam int unsigned V_FRONT_720P  = 5;
  localparam int unsigned V_SYNC_720P   = 5;
  localparam int unsigned V_BACK_720P   = 20;

  localparam int unsigned XPOS_W = 11;
  localparam int unsigned YPOS_W = 10;

  localparam int unsigned BAR_COUNT      = 8;
  localparam int unsigned BAR_WIDTH_720P = H_ACTIVE_720P / BAR_COUNT;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_GRID  = 2'd3
  } pattern_t;

  // Colour bars, left to right.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hC0C0C0;
      3'd1:    c = 24'hC0C000;
      3'd2:    c = 24'h00C0C0;
      3'd3:    c = 24'h00C000;
      3'd4:    c = 24'hC000C0;
      3'd5:    c = 24'hC00000;
      3'd6:    c = 24'h0000C0;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_patgen.sv
// video_patgen
//   Background pattern source. Decodes the pixel colour from the
//   coordinates of the current counter state and registers it, so rgb
//   lines up with the other registered timing outputs of the top.
// Ports:
//   clock_sig, reset_sig  pixel clock, async active-high reset
//   active                current counter state lies in the active area
//   xpos, y_lsb           active coordinates (y low byte only)
//   pattern_sel, bg_color settings sampled at frame start
//   frame_cnt             frame number for the ramp pattern
//   rgb                   registered {R,G,B}, 0 outside active
module video_patgen import video_syncgen_pkg::*; #(
  parameter int unsigned BAR_W = BAR_WIDTH_720P
) (
  input  logic              clock_sig,
  input  logic              reset_sig,
  input  logic              active,
  input  logic [XPOS_W-1:0] xpos,
  input  logic [7:0]        y_lsb,
  input  pattern_t          pattern_sel,
  input  logic [23:0]       bg_color,
  input  logic [7:0]        frame_cnt,
  output logic [23:0]       rgb
);

  localparam logic [XPOS_W-1:0] BAR_LAST = XPOS_W'(BAR_W - 1);

  logic [XPOS_W-1:0] bar_cnt;
  logic [2:0]        bar_idx;
  logic [XPOS_W-1:0] cur_cnt;
  logic [2:0]        cur_idx;
  logic              line_first;
  logic [23:0]       pix;

  always_comb begin
    // The bar sub-counter restarts on the first active pixel of each line,
    // so the first pixel uses index 0 regardless of what is stored.
    line_first = active && (xpos == '0);
    cur_cnt    = line_first ? '0 : bar_cnt;
    cur_idx    = line_first ? '0 : bar_idx;
    case (pattern_sel)
      PAT_SOLID: pix = bg_color;
      PAT_BARS:  pix = bar_color(cur_idx);
      PAT_RAMP:  pix = {xpos[7:0], y_lsb, frame_cnt};
      PAT_GRID:  pix = ((xpos[5:0] == 6'd0) || (y_lsb[5:0] == 6'd0)) ?
                       24'hFFFFFF : bg_color;
      default:   pix = bg_color;
    endcase
  end

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      rgb     <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
    end else begin
      rgb <= active ? pix : 24'h000000;
      if (active) begin
        if (cur_cnt == BAR_LAST) begin
          bar_cnt <= '0;
          bar_idx <= cur_idx + 3'd1;
        end else begin
          bar_cnt <= cur_cnt + 1'b1;
          bar_idx <= cur_idx;
        end
      end
    end
  end

endmodule

// File: rtl/video_syncgen.sv
// video_syncgen
//   Video timing generator (720p60 by default) with built-in background
//   pattern. Every output is registered one clock after the counter state
//   it describes, so all outputs are mutually aligned.
// Ports:
//   clock_sig, reset_sig     pixel clock, async active-high reset
//   enable                   async run request (2-FF synchronised)
//   pattern_sel, bg_color    pattern choice / background, taken at frame start
//   active_out               pixel valid
//   r_out, g_out, b_out      pixel colour
//   hsyncn_out, vsyncn_out   active-low syncs
//   xpos_out, ypos_out       active coordinates, 0 outside active
//   frame_top                pulse on the first active pixel of a frame
module video_syncgen import video_syncgen_pkg::*; #(
  parameter int unsigned H_ACTIVE = H_ACTIVE_720P,
  parameter int unsigned H_FRONT  = H_FRONT_720P,
  parameter int unsigned H_SYNC   = H_SYNC_720P,
  parameter int unsigned H_BACK   = H_BACK_720P,
  parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
  parameter int unsigned V_FRONT  = V_FRONT_720P,
  parameter int unsigned V_SYNC   = V_SYNC_720P,
  parameter int unsigned V_BACK   = V_BACK_720P
) (
  input  logic              clock_sig,
  input  logic              reset_sig,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  input  logic [23:0]       bg_color,
  output logic              active_out,
  output logic [7:0]        r_out,
  output logic [7:0]        g_out,
  output logic [7:0]        b_out,
  output logic              hsyncn_out,
  output logic              vsyncn_out,
  output logic [XPOS_W-1:0] xpos_out,
  output logic [YPOS_W-1:0] ypos_out,
  output logic              frame_top
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [XPOS_W-1:0] H_SYNC_END = XPOS_W'(H_SYNC);
  localparam logic [XPOS_W-1:0] H_ACT_BEG  = XPOS_W'(H_SYNC + H_BACK);
  localparam logic [XPOS_W-1:0] H_ACT_END  = XPOS_W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [XPOS_W-1:0] H_LAST     = XPOS_W'(H_TOTAL - 1);
  localparam logic [YPOS_W-1:0] V_SYNC_END = YPOS_W'(V_SYNC);
  localparam logic [YPOS_W-1:0] V_ACT_BEG  = YPOS_W'(V_SYNC + V_BACK);
  localparam logic [YPOS_W-1:0] V_ACT_END  = YPOS_W'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [YPOS_W-1:0] V_LAST     = YPOS_W'(V_TOTAL - 1);

  logic              en_meta;
  logic              en_sync;
  logic [XPOS_W-1:0] hcount;
  logic [YPOS_W-1:0] vcount;
  logic [7:0]        frame_cnt;
  pattern_t          pat_q;
  logic [23:0]       bg_q;

  logic              in_active;
  logic              hsync_d;
  logic              vsync_d;
  logic              top_d;
  logic              frame_start;
  logic [XPOS_W-1:0] x_d;
  logic [YPOS_W-1:0] y_d;
  logic [23:0]       rgb;

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      en_meta <= 1'b0;
      en_sync <= 1'b0;
    end else begin
      en_meta <= enable;
      en_sync <= en_meta;
    end
  end

  // While stopped the counters sit at 0, so the first running cycle is
  // always the start of a frame.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      hcount <= '0;
      vcount <= '0;
    end else if (!en_sync) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  // Frame number only advances on completed frames; an aborted frame
  // leaves it unchanged.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      frame_cnt <= '0;
      pat_q     <= PAT_SOLID;
      bg_q      <= '0;
    end else begin
      if (en_sync && (hcount == H_LAST) && (vcount == V_LAST)) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (frame_start) begin
        pat_q <= pattern_t'(pattern_sel);
        bg_q  <= bg_color;
      end
    end
  end

  always_comb begin
    frame_start = en_sync && (hcount == '0) && (vcount == '0);
    in_active   = en_sync &&
                  (hcount >= H_ACT_BEG) && (hcount < H_ACT_END) &&
                  (vcount >= V_ACT_BEG) && (vcount < V_ACT_END);
    hsync_d     = en_sync && (hcount < H_SYNC_END);
    vsync_d     = en_sync && (vcount < V_SYNC_END);
    top_d       = in_active && (hcount == H_ACT_BEG) && (vcount == V_ACT_BEG);
    x_d         = in_active ? (hcount - H_ACT_BEG) : '0;
    y_d         = in_active ? (vcount - V_ACT_BEG) : '0;
  end

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      active_out <= 1'b0;
      hsyncn_out <= 1'b1;
      vsyncn_out <= 1'b1;
      xpos_out   <= '0;
      ypos_out   <= '0;
      frame_top  <= 1'b0;
    end else begin
      active_out <= in_active;
      hsyncn_out <= ~hsync_d;
      vsyncn_out <= ~vsync_d;
      xpos_out   <= x_d;
      ypos_out   <= y_d;
      frame_top  <= top_d;
    end
  end

  video_patgen #(
    .BAR_W (H_ACTIVE / BAR_COUNT)
  ) u_patgen (
    .clock_sig   (clock_sig),
    .reset_sig   (reset_sig),
    .active      (in_active),
    .xpos        (x_d),
    .y_lsb       (y_d[7:0]),
    .pattern_sel (pat_q),
    .bg_color    (bg_q),
    .frame_cnt   (frame_cnt),
    .rgb         (rgb)
  );

  assign r_out = rgb[23:16];
  assign g_out = rgb[15:8];
  assign b_out = rgb[7:0];

endmodule

// File: tb/tb_video_syncgen.sv
// Bench for video_syncgen using a shrunken raster so that whole frames and
// the 8-bit frame-counter wrap fit in a short run.
module tb_video_syncgen;

  localparam int HA = 16, HF = 1, HS = 3, HB = 2;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 22
  localparam int VT = VA + VF + VS + VB;   // 10
  localparam int FT = HT * VT;             // 220
  localparam logic [48:0] IDLE_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 11'h0, 10'h0};

  logic        clock_sig = 1'b0;
  logic        reset_sig;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [23:0] bg_color;
  logic        active_out;
  logic [7:0]  r_out, g_out, b_out;
  logic        hsyncn_out, vsyncn_out;
  logic [10:0] xpos_out;
  logic [9:0]  ypos_out;
  logic        frame_top;
  logic [48:0] out_vec;

  int tests = 0;
  int fails = 0;

  assign out_vec = {active_out, hsyncn_out, vsyncn_out, frame_top,
                    r_out, g_out, b_out, xpos_out, ypos_out};

  video_syncgen #(
    .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
  ) dut (
    .clock_sig   (clock_sig),
    .reset_sig   (reset_sig),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .bg_color    (bg_color),
    .active_out  (active_out),
    .r_out       (r_out),
    .g_out       (g_out),
    .b_out       (b_out),
    .hsyncn_out  (hsyncn_out),
    .vsyncn_out  (vsyncn_out),
    .xpos_out    (xpos_out),
    .ypos_out    (ypos_out),
    .frame_top   (frame_top)
  );

  always #5 clock_sig = ~clock_sig;

  task automatic tick();
    @(posedge clock_sig);
    #1;
  endtask

  function automatic logic [23:0] bar_ref(input int idx);
    case (idx)
      0: return 24'hC0C0C0;
      1: return 24'hC0C000;
      2: return 24'h00C0C0;
      3: return 24'h00C000;
      4: return 24'hC000C0;
      5: return 24'hC00000;
      6: return 24'h0000C0;
      default: return 24'h000000;
    endcase
  endfunction

  // Starts on the sample of frame cycle 0 and ends on the next frame's cycle 0.
  task automatic scan_frame(input string name, input int pat, input logic [23:0] bg_exp,
                            input logic [7:0] fnum, input int sw_line,
                            input logic [1:0] sw_sel, input logic [23:0] sw_bg);
    int n_hs = 0, n_vs = 0, n_act = 0, n_top = 0, n_err = 0;
    for (int i = 0; i < FT; i++) begin
      int h, v, x, y;
      logic act;
      logic [23:0] rgb;
      logic [48:0] exp_vec;
      h = i % HT;
      v = i / HT;
      act = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
      x = act ? h - (HS + HB) : 0;
      y = act ? v - (VS + VB) : 0;
      rgb = 24'h0;
      if (act) begin
        case (pat)
          0: rgb = bg_exp;
          1: rgb = bar_ref(x / (HA / 8));
          2: rgb = {8'(x), 8'(y), fnum};
          default: rgb = ((x % 64) == 0 || (y % 64) == 0) ? 24'hFFFFFF : bg_exp;
        endcase
      end
      exp_vec = {act, ~(h < HS), ~(v < VS), (act && x == 0 && y == 0),
                 rgb, 11'(x), 10'(y)};
      if (out_vec !== exp_vec) begin
        n_err++;
        if (n_err == 1)
          $display("  %s: first difference at h=%0d v=%0d got %h want %h", name, h, v, out_vec, exp_vec);
      end
      if (hsyncn_out === 1'b0) n_hs++;
      if (vsyncn_out === 1'b0) n_vs++;
      if (active_out === 1'b1) n_act++;
      if (frame_top === 1'b1) n_top++;
      if (v == sw_line && h == 0) begin
        pattern_sel = sw_sel;
        bg_color    = sw_bg;
      end
      tick();
    end
    tests++;
    if (n_err !== 0) begin fails++; $display("FAIL %s pixel/timing: %0d differing cycles, expected 0", name, n_err); end
    tests++;
    if (n_hs !== HS * VT) begin fails++; $display("FAIL %s hsync_low_cycles: got %0d expected %0d", name, n_hs, HS * VT); end
    tests++;
    if (n_vs !== VS * HT) begin fails++; $display("FAIL %s vsync_low_cycles: got %0d expected %0d", name, n_vs, VS * HT); end
    tests++;
    if (n_act !== HA * VA) begin fails++; $display("FAIL %s active_cycles: got %0d expected %0d", name, n_act, HA * VA); end
    tests++;
    if (n_top !== 1) begin fails++; $display("FAIL %s frame_top_pulses: got %0d expected 1", name, n_top); end
    tests++;
    if ({hsyncn_out, vsyncn_out} !== 2'b00) begin
      fails++;
      $display("FAIL %s frame_period: syncs got %b expected 00 at cycle %0d", name, {hsyncn_out, vsyncn_out}, FT);
    end
  endtask

  task automatic test_reset();
    reset_sig   = 1'b1;
    enable      = 1'b0;
    pattern_sel = 2'd1;
    bg_color    = 24'h123456;
    #12;
    tests++;
    if (out_vec !== IDLE_VEC) begin fails++; $display("FAIL reset_values: got %h expected %h", out_vec, IDLE_VEC); end
    reset_sig = 1'b0;
    repeat (4) tick();
    tests++;
    if (out_vec !== IDLE_VEC) begin fails++; $display("FAIL idle_while_disabled: got %h expected %h", out_vec, IDLE_VEC); end
  endtask

  task automatic test_enable_start();
    enable = 1'b1;
    tick();
    tests++;
    if (hsyncn_out !== 1'b1) begin fails++; $display("FAIL start_clk1_hsyncn: got %b expected 1", hsyncn_out); end
    tick();
    tests++;
    if (hsyncn_out !== 1'b1) begin fails++; $display("FAIL start_clk2_hsyncn: got %b expected 1", hsyncn_out); end
    tick();
    tests++;
    if ({hsyncn_out, vsyncn_out, active_out} !== 3'b000) begin
      fails++;
      $display("FAIL start_clk3_syncs: got %b expected 000", {hsyncn_out, vsyncn_out, active_out});
    end
  endtask

  task automatic test_pattern_frames();
    scan_frame("bars_f0",  1, 24'h123456, 8'd0, 6,  2'd0, 24'h123456);
    scan_frame("solid_f1", 0, 24'h123456, 8'd1, 5,  2'd1, 24'hAABBCC);
    scan_frame("bars_f2",  1, 24'hAABBCC, 8'd2, 4,  2'd3, 24'hAABBCC);
    scan_frame("grid_f3",  3, 24'hAABBCC, 8'd3, 7,  2'd2, 24'h000000);
    scan_frame("ramp_f4",  2, 24'h000000, 8'd4, -1, 2'd0, 24'h000000);
  endtask

  task automatic test_enable_drop();
    repeat (5 * HT + 10) tick();
    enable = 1'b0;
    tick();
    tick();
    tests++;
    if ({active_out, xpos_out} !== {1'b1, 11'd7}) begin
      fails++;
      $display("FAIL drop_clk2_still_running: got active=%b x=%0d expected active=1 x=7", active_out, xpos_out);
    end
    tick();
    tests++;
    if (out_vec !== IDLE_VEC) begin fails++; $display("FAIL drop_clk3_idle: got %h expected %h", out_vec, IDLE_VEC); end
    repeat (4) tick();
    tests++;
    if (out_vec !== IDLE_VEC) begin fails++; $display("FAIL drop_held_idle: got %h expected %h", out_vec, IDLE_VEC); end
    enable = 1'b1;
    tick();
    tick();
    tests++;
    if (out_vec !== IDLE_VEC) begin fails++; $display("FAIL reenable_clk2_idle: got %h expected %h", out_vec, IDLE_VEC); end
    tick();
    tests++;
    if ({hsyncn_out, vsyncn_out} !== 2'b00) begin
      fails++;
      $display("FAIL reenable_clk3_syncs: got %b expected 00", {hsyncn_out, vsyncn_out});
    end
    scan_frame("restart_f5", 2, 24'h000000, 8'd5, -1, 2'd0, 24'h000000);
  endtask

  task automatic test_async_reset();
    repeat (3 * HT + 8) tick();
    tests++;
    if ({active_out, xpos_out} !== {1'b1, 11'd3}) begin
      fails++;
      $display("FAIL pre_reset_active: got active=%b x=%0d expected active=1 x=3", active_out, xpos_out);
    end
    #2;
    reset_sig = 1'b1;
    #1;
    tests++;
    if (out_vec !== IDLE_VEC) begin fails++; $display("FAIL async_reset_immediate: got %h expected %h", out_vec, IDLE_VEC); end
    tick();
    tick();
    reset_sig = 1'b0;
  endtask

  task automatic test_ramp_wrap();
    int n = 0;
    while (hsyncn_out !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    tests++;
    if (n !== 3) begin fails++; $display("FAIL restart_after_reset_latency: got %0d clocks expected 3", n); end
    scan_frame("ramp_w0", 2, 24'h000000, 8'd0, -1, 2'd0, 24'h000000);
    repeat (254 * FT) tick();
    scan_frame("ramp_w255", 2, 24'h000000, 8'd255, -1, 2'd0, 24'h000000);
    scan_frame("ramp_w256", 2, 24'h000000, 8'd0, -1, 2'd0, 24'h000000);
  endtask

  initial begin
    test_reset();
    test_enable_start();
    test_pattern_frames();
    test_enable_drop();
    test_async_reset();
    test_ramp_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
